// File: rtl/range_stream_encoder.sv
// range_stream_encoder
// Decodes an ASCII byte stream of "L-U\n" range lines, one blank line, then
// "N\n" ingredient-ID lines into a stream of numbers for the range-check chain.
//
// Ports:
//   clk                        single clock, rising edge
//   rst_n                      synchronous active-low reset
//   inbound_valid              qualifies inbound_data for one cycle (no backpressure)
//   inbound_data[7:0]          ASCII input byte
//   downstream_id_range_sel    0 while emitting range bounds, 1 once in the ID section
//   downstream_id_range_valid  one-cycle strobe per emitted number
//   downstream_id_range_data   emitted number (holds when valid is low)
//   parse_error                sticky malformed-input flag
module range_stream_encoder #(
    parameter int unsigned INGREDIENT_ID_RANGE_WIDTH = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 inbound_valid,
    input  logic [7:0]                           inbound_data,
    output logic                                 downstream_id_range_sel,
    output logic                                 downstream_id_range_valid,
    output logic [INGREDIENT_ID_RANGE_WIDTH-1:0] downstream_id_range_data,
    output logic                                 parse_error
);

    localparam int unsigned W = INGREDIENT_ID_RANGE_WIDTH;

    localparam logic [7:0] CHAR_DASH = 8'h2D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [7:0] CHAR_0    = 8'h30;
    localparam logic [7:0] CHAR_9    = 8'h39;

    typedef enum logic [1:0] {
        RANGE_LOWER = 2'd0,
        RANGE_UPPER = 2'd1,
        IDS         = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           seen_q, seen_d;
    logic           sel_q, sel_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   data_q, data_d;
    logic           err_q, err_d;

    logic           is_digit;
    logic           is_dash;
    logic           is_lf;
    logic [W-1:0]   acc_next;

    // Byte classification; anything else (including CR) is ignored.
    always_comb begin
        is_digit = inbound_valid && (inbound_data >= CHAR_0) && (inbound_data <= CHAR_9);
        is_dash  = inbound_valid && (inbound_data == CHAR_DASH);
        is_lf    = inbound_valid && (inbound_data == CHAR_LF);
    end

    // acc*10 + digit via shifts, wrapping modulo 2^W; low nibble of '0'..'9' is the digit.
    always_comb begin
        acc_next = W'((acc_q << 3) + (acc_q << 1) + W'(inbound_data[3:0]));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RANGE_LOWER;
            acc_q   <= '0;
            seen_q  <= 1'b0;
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            seen_q  <= seen_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Next-state, accumulator and emission decisions.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        seen_d  = seen_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        data_d  = data_q;
        err_d   = err_q;

        if (is_digit) begin
            acc_d  = acc_next;
            seen_d = 1'b1;
        end else if (is_dash) begin
            // Every separator clears the number in progress, emitted or not.
            acc_d  = '0;
            seen_d = 1'b0;
            case (state_q)
                RANGE_LOWER: begin
                    if (seen_q) begin
                        valid_d = 1'b1;
                        data_d  = acc_q;
                        state_d = RANGE_UPPER;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                RANGE_UPPER: err_d = 1'b1;
                IDS:         err_d = 1'b1;
                default:     state_d = RANGE_LOWER;
            endcase
        end else if (is_lf) begin
            acc_d  = '0;
            seen_d = 1'b0;
            case (state_q)
                RANGE_LOWER: begin
                    if (seen_q) begin
                        // Line ended without a '-': drop it and restart the line.
                        err_d = 1'b1;
                    end else begin
                        // Blank line: switch sections. sel only moves here, never
                        // alongside a range-bound strobe.
                        state_d = IDS;
                        sel_d   = 1'b1;
                    end
                end
                RANGE_UPPER: begin
                    if (seen_q) begin
                        valid_d = 1'b1;
                        data_d  = acc_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = RANGE_LOWER;
                end
                IDS: begin
                    // Extra blank lines in the ID section are harmless.
                    if (seen_q) begin
                        valid_d = 1'b1;
                        data_d  = acc_q;
                    end
                end
                default: state_d = RANGE_LOWER;
            endcase
        end
    end

    assign downstream_id_range_sel   = sel_q;
    assign downstream_id_range_valid = valid_q;
    assign downstream_id_range_data  = data_q;
    assign parse_error               = err_q;

endmodule

// File: tb/tb_range_stream_encoder.sv
// Directed bench for range_stream_encoder: a 64-bit instance for the main
// scenarios and an 8-bit instance for accumulator wrap-around.
module tb_range_stream_encoder;

    typedef logic [64:0] ent_t;   // {sel, data}

    logic        clk;
    logic        rst_n;
    logic        inbound_valid;
    logic [7:0]  inbound_data;

    logic        sel64, valid64, err64;
    logic [63:0] data64;
    logic        sel8, valid8, err8;
    logic [7:0]  data8;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ent_t q64[$];
    ent_t q8[$];
    ent_t e[$];

    range_stream_encoder #(.INGREDIENT_ID_RANGE_WIDTH(64)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .inbound_valid             (inbound_valid),
        .inbound_data              (inbound_data),
        .downstream_id_range_sel   (sel64),
        .downstream_id_range_valid (valid64),
        .downstream_id_range_data  (data64),
        .parse_error               (err64)
    );

    range_stream_encoder #(.INGREDIENT_ID_RANGE_WIDTH(8)) dut8 (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .inbound_valid             (inbound_valid),
        .inbound_data              (inbound_data),
        .downstream_id_range_sel   (sel8),
        .downstream_id_range_valid (valid8),
        .downstream_id_range_data  (data8),
        .parse_error               (err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe collectors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && valid64) q64.push_back({sel64, data64});
        if (rst_n && valid8)  q8.push_back({sel8, 56'd0, data8});
    end

    function automatic ent_t ent(input logic s, input logic [63:0] d);
        return {s, d};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_q(input string tag, input ent_t got[$], input ent_t exp[$]);
        chk({tag, "_count"}, 65'(got.size()), 65'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) begin
                chk($sformatf("%s_sel%0d", tag, i), 65'(got[i][64]), 65'(exp[i][64]));
                chk($sformatf("%s_data%0d", tag, i), 65'(got[i][63:0]), 65'(exp[i][63:0]));
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        inbound_valid = 1'b1;
        inbound_data  = b;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            inbound_valid = 1'b0;
            inbound_data  = 8'h00;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n         = 1'b0;
        inbound_valid = 1'b0;
        inbound_data  = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        q64.delete();
        q8.delete();
    endtask

    initial begin
        rst_n         = 1'b0;
        inbound_valid = 1'b0;
        inbound_data  = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_sel",   65'(sel64),   65'd0);
        chk("rst_valid", 65'(valid64), 65'd0);
        chk("rst_data",  65'(data64),  65'd0);
        chk("rst_err",   65'(err64),   65'd0);
        rst_n = 1'b1;

        // Basic stream with section switch
        reset_dut();
        send_str("3-5\n10-14\n");
        send(8'h0A);                       // blank line being driven
        chk("s1_last_upper_valid", 65'(valid64), 65'd1);
        chk("s1_last_upper_data",  65'(data64),  65'd14);
        chk("s1_last_upper_sel",   65'(sel64),   65'd0);
        send("1");                         // blank LF sampled on the previous edge
        chk("s1_sel_rise", 65'(sel64),   65'd1);
        chk("s1_no_strobe", 65'(valid64), 65'd0);
        send_str("\n5\n");
        idle(2);
        e = {ent(0, 3), ent(0, 5), ent(0, 10), ent(0, 14), ent(1, 1), ent(1, 5)};
        check_q("s1", q64, e);
        chk("s1_data_hold", 65'(data64), 65'd5);
        chk("s1_sel_stays", 65'(sel64),  65'd1);
        chk("s1_err",       65'(err64),  65'd0);

        // CR is ignored; strobe latency of one cycle
        reset_dut();
        send_str("12-");
        send("3");
        chk("s2_lower_valid", 65'(valid64), 65'd1);
        chk("s2_lower_data",  65'(data64),  65'd12);
        send("4");
        chk("s2_gap_valid", 65'(valid64), 65'd0);
        send(8'h0D);
        send(8'h0A);
        chk("s2_cr_no_strobe", 65'(valid64), 65'd0);
        idle(1);
        chk("s2_upper_valid", 65'(valid64), 65'd1);
        chk("s2_upper_data",  65'(data64),  65'd34);
        idle(1);
        e = {ent(0, 12), ent(0, 34)};
        check_q("s2", q64, e);
        chk("s2_err", 65'(err64), 65'd0);

        // 8-bit accumulator wraps: 300 mod 256 = 44
        reset_dut();
        send_str("300-7\n");
        idle(2);
        e = {ent(0, 44), ent(0, 7)};
        check_q("s3_w8", q8, e);
        chk("s3_w8_err", 65'(err8), 65'd0);

        // Dash without a number flags an error; decoding continues
        reset_dut();
        send("-");
        send("5");
        chk("s4_err_set", 65'(err64), 65'd1);
        chk("s4_no_strobe", 65'(valid64), 65'd0);
        send_str("\n2-4\n");
        idle(2);
        e = {ent(0, 2), ent(0, 4)};
        check_q("s4", q64, e);
        chk("s4_err_sticky", 65'(err64), 65'd1);
        chk("s4_sel", 65'(sel64), 65'd0);

        // Empty upper bound: error, back to lower bound
        reset_dut();
        send_str("5-\n6-7\n");
        idle(2);
        e = {ent(0, 5), ent(0, 6), ent(0, 7)};
        check_q("s5", q64, e);
        chk("s5_err", 65'(err64), 65'd1);

        // Mid-line reset drops partial number; first byte after reset decodes
        reset_dut();
        send_str("12");
        @(negedge clk);
        rst_n         = 1'b0;
        inbound_valid = 1'b1;
        inbound_data  = "3";
        @(negedge clk);
        rst_n         = 1'b1;
        inbound_valid = 1'b1;
        inbound_data  = "4";
        chk("s6_rst_valid", 65'(valid64), 65'd0);
        chk("s6_rst_data",  65'(data64),  65'd0);
        send_str("-6\n");
        idle(2);
        e = {ent(0, 4), ent(0, 6)};
        check_q("s6", q64, e);
        chk("s6_sel", 65'(sel64), 65'd0);
        chk("s6_err", 65'(err64), 65'd0);

        // Immediate blank line, extra blanks in the ID section
        reset_dut();
        send(8'h0A);
        send("7");
        chk("s7_sel_rise", 65'(sel64), 65'd1);
        send_str("\n\n8\n");
        idle(2);
        e = {ent(1, 7), ent(1, 8)};
        check_q("s7", q64, e);
        chk("s7_err", 65'(err64), 65'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
